ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. It sits directly downstream of the ID/EX register and consumes its outputs. It performs ALU control decode, the ALU operation, branch-target computation and destination-register selection, then registers the results into the EX/MEM boundary. A compile-time iterative multiplier adds multi-cycle R-type `mult`; while it runs, the block stalls upstream stages and inserts bubbles downstream.

## Interface
- No parameters; widths are fixed at 32-bit data, 5-bit register index and 6-bit funct.
- clk  in  1  pipeline clock, rising edge
- startin_n  in  1  reset, asynchronous, active-low
- EX_wb  in  2  WB control from ID/EX
- EX_m  in  3  MEM control from ID/EX
- EX_reg_dst  in  1  1 selects instr[15:11], 0 selects instr[20:16]
- EX_alu_op  in  2  ALU op class
- EX_alu_src  in  1  1 selects sign-extended immediate as operand B
- EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm  in  32 each  datapath inputs
- EX_instr_20_16, EX_instr_15_11  in  5 each  destination candidates
- ex_stall  out  1  freeze PC, IF/ID and ID/EX (combinational)
- MEM_wb  out  2; MEM_m  out  3  registered control
- MEM_branch_target  out  32  registered pc_plus_4 + (imm << 2)
- MEM_zero  out  1  registered, alu_result == 0
- MEM_alu_result  out  32  registered ALU/product result
- MEM_write_data  out  32  registered EX_reg_data2
- MEM_write_reg  out  5  registered selected destination

## Operation
- Operand A = reg_data1. Operand B = alu_src ? sign_ext_imm : reg_data2.
- alu_op 00: add. 01: sub. 11: OR. 10: decode funct = sign_ext_imm[5:0]: 100000 add, 100010 sub, 100100 AND, 100101 OR, 101010 SLT (signed, result 0/1), 011000 MULT. Any other funct yields result 0.
- Add, sub and branch target all wrap modulo 2^32; no overflow flag.
- Multiplier FSM states:
  - IDLE: a decoded MULT goes to BUSY; the operands load, the accumulator clears and the counter goes to 0.
  - BUSY: each cycle does shift-add of one multiplier bit; the counter increments. counter==31 goes to DONE.
  - DONE: goes to IDLE unconditionally.
- The product is the low 32 bits of A×B (unsigned shift-add; the low word equals the signed low word).
- ex_stall = (IDLE && MULT decoded) || BUSY. It is low in DONE.
- EX/MEM register each edge:
  - When ex_stall=1, capture a bubble: MEM_wb=0 and MEM_m=0; the other fields hold their previous values.
  - Otherwise capture the current results. In DONE, alu_result = product.
- Upstream holds the EX_* inputs stable while ex_stall=1; the block does not re-check them mid-operation.

## Timing
- Non-MULT ops: latency 1 cycle, inputs to MEM_* on the next edge, no stall.
- MULT issued in cycle T: ex_stall is high T..T+32 (33 cycles). BUSY spans T+1..T+32. DONE is T+33, and MEM_alu_result = product after the edge ending T+33.
- A back-to-back MULT after DONE restarts from IDLE in T+34.
- Reset (startin_n=0, any time including mid-BUSY) immediately forces the following:
  - state=IDLE, counter=0, accumulator=0;
  - all MEM_* outputs 0, ex_stall=0.
- Release is synchronous to the next rising edge.

## Configuration
- EX_MULT_EN defined: multiplier FSM compiled in; behaviour as above.
- EX_MULT_EN undefined: no FSM or multiplier registers. funct 011000 falls into "other" (result 0), and ex_stall is tied 0.

## Structure
- Shared package ex_pkg holds:
  - ALU control enum: ADD, SUB, AND, OR, SLT, MULT, NOP;
  - funct constants;
  - alu_op encodings;
  - multiplier state enum (IDLE, BUSY, DONE).
- One sub-module, ex_mult_iter, contains the FSM, the 5-bit counter and the shift-add datapath.
  - Inputs: start, a, b.
  - Outputs: busy, done, product.
  - Instantiated only under EX_MULT_EN.

## Test plan
- add R-type: data1=5, data2=3, alu_op=10, funct=100000, reg_dst=1, rd=9 -> next edge MEM_alu_result=8, MEM_write_reg=9, MEM_zero=0.
- beq-style: alu_op=01, data1=data2=0x1234, pc_plus_4=0x100, imm=-2 -> MEM_zero=1, MEM_branch_target=0xF8.
- SLT signed: data1=0xFFFFFFFF, data2=1 -> result 1; swapped -> 0. alu_src=1 with imm=0xFFFFFFF0, lw path, alu_op=00, data1=0x20 -> result 0x10.
- MULT: 7×6 -> ex_stall high for exactly 33 cycles, MEM_wb/MEM_m=0 during stall, then MEM_alu_result=42. Repeat with 0xFFFFFFFF×2 -> 0xFFFFFFFE.
- Reset mid-MULT: assert startin_n=0 at BUSY counter=10 -> ex_stall and all MEM_* go 0 without a clock edge. After release, an add of 1+1 gives 2 with no stall.
- Without EX_MULT_EN: MULT funct -> result 0, ex_stall never asserted.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU control, funct codes,
// alu_op classes and multiplier states. MULT decodes only when EX_MULT_EN is defined.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MULT,
    ALU_NOP
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_BUSY,
    MULT_DONE
  } mult_state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                           input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_NOP;
    case (alu_op)
      ALU_OP_ADD: ctrl = ALU_ADD;
      ALU_OP_SUB: ctrl = ALU_SUB;
      ALU_OP_OR:  ctrl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD:  ctrl = ALU_ADD;
          FUNCT_SUB:  ctrl = ALU_SUB;
          FUNCT_AND:  ctrl = ALU_AND;
          FUNCT_OR:   ctrl = ALU_OR;
          FUNCT_SLT:  ctrl = ALU_SLT;
`ifdef EX_MULT_EN
          FUNCT_MULT: ctrl = ALU_MULT;
`endif
          default:    ctrl = ALU_NOP;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_mult_iter.sv
// Iterative 32x32 shift-add multiplier (low word): IDLE -> BUSY (32 cycles) -> DONE.
// FSM state is exposed on state_o for observation.
module ex_mult_iter
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o,
  output mult_state_e state_o
);

  mult_state_e state_q;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MULT_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        MULT_IDLE: begin
          if (start_i) begin
            state_q  <= MULT_BUSY;
            mcand_q  <= b_i;
            mplier_q <= a_i;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MULT_BUSY: begin
          // One multiplier bit per cycle; bits above 31 fall off the shifted multiplicand.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= MULT_DONE;
        end
        MULT_DONE: state_q <= MULT_IDLE;
        default:   state_q <= MULT_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == MULT_BUSY);
  assign done_o    = (state_q == MULT_DONE);
  assign product_o = acc_q;
  assign state_o   = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU decode/operation, branch target, destination select, EX/MEM register.
// EX_MULT_EN compiles in the iterative multiplier and its upstream stall.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        startin_n,
  input  logic [1:0]  EX_wb,
  input  logic [2:0]  EX_m,
  input  logic        EX_reg_dst,
  input  logic [1:0]  EX_alu_op,
  input  logic        EX_alu_src,
  input  logic [31:0] EX_pc_plus_4,
  input  logic [31:0] EX_reg_data1,
  input  logic [31:0] EX_reg_data2,
  input  logic [31:0] EX_sign_ext_imm,
  input  logic [4:0]  EX_instr_20_16,
  input  logic [4:0]  EX_instr_15_11,
  output logic        ex_stall,
  output logic [1:0]  MEM_wb,
  output logic [2:0]  MEM_m,
  output logic [31:0] MEM_branch_target,
  output logic        MEM_zero,
  output logic [31:0] MEM_alu_result,
  output logic [31:0] MEM_write_data,
  output logic [4:0]  MEM_write_reg
);

  alu_ctrl_e   alu_ctrl;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [31:0] ex_result;
  logic [31:0] branch_target;
  logic [4:0]  write_reg;
  logic        stall;

  logic [1:0]  mem_wb_q;
  logic [2:0]  mem_m_q;
  logic [31:0] mem_bt_q;
  logic        mem_zero_q;
  logic [31:0] mem_res_q;
  logic [31:0] mem_wd_q;
  logic [4:0]  mem_wr_q;

  assign op_b          = EX_alu_src ? EX_sign_ext_imm : EX_reg_data2;
  assign alu_ctrl      = alu_decode(EX_alu_op, EX_sign_ext_imm[5:0]);
  assign branch_target = EX_pc_plus_4 + {EX_sign_ext_imm[29:0], 2'b00};
  assign write_reg     = EX_reg_dst ? EX_instr_15_11 : EX_instr_20_16;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD: alu_result = EX_reg_data1 + op_b;
      ALU_SUB: alu_result = EX_reg_data1 - op_b;
      ALU_AND: alu_result = EX_reg_data1 & op_b;
      ALU_OR:  alu_result = EX_reg_data1 | op_b;
      ALU_SLT: alu_result = {31'b0, ($signed(EX_reg_data1) < $signed(op_b))};
      default: alu_result = '0;
    endcase
  end

`ifdef EX_MULT_EN
  logic        mult_busy;
  logic        mult_done;
  logic [31:0] mult_product;
  mult_state_e mult_state;

  ex_mult_iter u_mult (
    .clk_i     (clk),
    .rst_ni    (startin_n),
    .start_i   (alu_ctrl == ALU_MULT),
    .a_i       (EX_reg_data1),
    .b_i       (op_b),
    .busy_o    (mult_busy),
    .done_o    (mult_done),
    .product_o (mult_product),
    .state_o   (mult_state)
  );

  // Gated by reset so the stall drops immediately even with a MULT still presented.
  assign stall     = startin_n &
                     (((alu_ctrl == ALU_MULT) && (mult_state == MULT_IDLE)) || mult_busy);
  assign ex_result = mult_done ? mult_product : alu_result;
`else
  assign stall     = 1'b0;
  assign ex_result = alu_result;
`endif

  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      mem_wb_q   <= '0;
      mem_m_q    <= '0;
      mem_bt_q   <= '0;
      mem_zero_q <= 1'b0;
      mem_res_q  <= '0;
      mem_wd_q   <= '0;
      mem_wr_q   <= '0;
    end else if (stall) begin
      mem_wb_q <= '0;
      mem_m_q  <= '0;
    end else begin
      mem_wb_q   <= EX_wb;
      mem_m_q    <= EX_m;
      mem_bt_q   <= branch_target;
      mem_zero_q <= (ex_result == 32'd0);
      mem_res_q  <= ex_result;
      mem_wd_q   <= EX_reg_data2;
      mem_wr_q   <= write_reg;
    end
  end

  assign ex_stall          = stall;
  assign MEM_wb            = mem_wb_q;
  assign MEM_m             = mem_m_q;
  assign MEM_branch_target = mem_bt_q;
  assign MEM_zero          = mem_zero_q;
  assign MEM_alu_result    = mem_res_q;
  assign MEM_write_data    = mem_wd_q;
  assign MEM_write_reg     = mem_wr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, randomized ops against a reference
// model, multiplier timing (EX_MULT_EN) or its absence, and asynchronous reset.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk;
  logic        startin_n;
  logic [1:0]  EX_wb;
  logic [2:0]  EX_m;
  logic        EX_reg_dst;
  logic [1:0]  EX_alu_op;
  logic        EX_alu_src;
  logic [31:0] EX_pc_plus_4;
  logic [31:0] EX_reg_data1;
  logic [31:0] EX_reg_data2;
  logic [31:0] EX_sign_ext_imm;
  logic [4:0]  EX_instr_20_16;
  logic [4:0]  EX_instr_15_11;
  logic        ex_stall;
  logic [1:0]  MEM_wb;
  logic [2:0]  MEM_m;
  logic [31:0] MEM_branch_target;
  logic        MEM_zero;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_write_data;
  logic [4:0]  MEM_write_reg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;

  ex_stage dut (
    .clk               (clk),
    .startin_n         (startin_n),
    .EX_wb             (EX_wb),
    .EX_m              (EX_m),
    .EX_reg_dst        (EX_reg_dst),
    .EX_alu_op         (EX_alu_op),
    .EX_alu_src        (EX_alu_src),
    .EX_pc_plus_4      (EX_pc_plus_4),
    .EX_reg_data1      (EX_reg_data1),
    .EX_reg_data2      (EX_reg_data2),
    .EX_sign_ext_imm   (EX_sign_ext_imm),
    .EX_instr_20_16    (EX_instr_20_16),
    .EX_instr_15_11    (EX_instr_15_11),
    .ex_stall          (ex_stall),
    .MEM_wb            (MEM_wb),
    .MEM_m             (MEM_m),
    .MEM_branch_target (MEM_branch_target),
    .MEM_zero          (MEM_zero),
    .MEM_alu_result    (MEM_alu_result),
    .MEM_write_data    (MEM_write_data),
    .MEM_write_reg     (MEM_write_reg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: result of an EX operation from the instruction-set rules.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [5:0] f);
    logic [31:0] r;
    r = 32'd0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (op == 2'b11) r = a | b;
    else begin
      if (f == F_ADD) r = a + b;
      else if (f == F_SUB) r = a - b;
      else if (f == F_AND) r = a & b;
      else if (f == F_OR) r = a | b;
      else if (f == F_SLT) r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef EX_MULT_EN
      else if (f == F_MULT) r = a * b;
`endif
      else r = 32'd0;
    end
    return r;
  endfunction

  // driver
  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic dst,
                       input logic [1:0] op, input logic src, input logic [31:0] pc4,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rt, input logic [4:0] rd);
    EX_wb = wb; EX_m = m; EX_reg_dst = dst; EX_alu_op = op; EX_alu_src = src;
    EX_pc_plus_4 = pc4; EX_reg_data1 = d1; EX_reg_data2 = d2; EX_sign_ext_imm = imm;
    EX_instr_20_16 = rt; EX_instr_15_11 = rd;
  endtask

  task automatic test_reset();
    startin_n = 1'b1;
    drive(2'b11, 3'b111, 1'b1, 2'b10, 1'b0, 32'h100, 32'd1, 32'd2, {26'd0, F_ADD}, 5'd1, 5'd2);
    #2 startin_n = 1'b0;
    #1;
    total++;
    if (ex_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", ex_stall); end
    total++;
    if ({MEM_wb, MEM_m, MEM_zero, MEM_write_reg} !== 11'd0) begin
      bad++; $display("FAIL reset_ctrl: got %h want 0", {MEM_wb, MEM_m, MEM_zero, MEM_write_reg});
    end
    total++;
    if ({MEM_branch_target, MEM_alu_result, MEM_write_data} !== 96'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {MEM_branch_target, MEM_alu_result, MEM_write_data});
    end
    @(negedge clk);
    startin_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        src;
    logic        dst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] res;
    logic        zero;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[9];
    logic [4:0] wr;
    tbl = '{
      '{2'b10, 1'b0, 1'b1, 32'd5,        32'd3,        32'h00000020, 32'h0,   32'd8,        1'b0},
      '{2'b01, 1'b0, 1'b0, 32'h1234,     32'h1234,     32'hFFFFFFFE, 32'h100, 32'd0,        1'b1},
      '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h0000002A, 32'h0,   32'd1,        1'b0},
      '{2'b10, 1'b0, 1'b1, 32'd1,        32'hFFFFFFFF, 32'h0000002A, 32'h0,   32'd0,        1'b1},
      '{2'b00, 1'b1, 1'b0, 32'h20,       32'h55,       32'hFFFFFFF0, 32'h40,  32'h10,       1'b0},
      '{2'b10, 1'b0, 1'b1, 32'd3,        32'd5,        32'h00000022, 32'h8,   32'hFFFFFFFE, 1'b0},
      '{2'b10, 1'b0, 1'b1, 32'hF0F0,     32'h0FF0,     32'h00000024, 32'h8,   32'h00F0,     1'b0},
      '{2'b11, 1'b1, 1'b0, 32'h00F0,     32'h1,        32'h00000F00, 32'h8,   32'h0FF0,     1'b0},
      '{2'b10, 1'b0, 1'b1, 32'd9,        32'd4,        32'h00000007, 32'h8,   32'd0,        1'b1}
    };
    for (int i = 0; i < 9; i++) begin
      drive(2'(i), 3'(i), tbl[i].dst, tbl[i].op, tbl[i].src, tbl[i].pc4, tbl[i].d1,
            tbl[i].d2, tbl[i].imm, 5'd3, 5'd9);
      wr = tbl[i].dst ? 5'd9 : 5'd3;
      #1;
      total++;
      if (ex_stall !== 1'b0) begin bad++; $display("FAIL dir%0d_stall: got %b want 0", i, ex_stall); end
      @(posedge clk); #1;
      total++;
      if (MEM_alu_result !== tbl[i].res) begin
        bad++; $display("FAIL dir%0d_result: got %h want %h", i, MEM_alu_result, tbl[i].res);
      end
      total++;
      if (MEM_zero !== tbl[i].zero) begin
        bad++; $display("FAIL dir%0d_zero: got %b want %b", i, MEM_zero, tbl[i].zero);
      end
      total++;
      if (MEM_branch_target !== tbl[i].pc4 + tbl[i].imm * 4) begin
        bad++; $display("FAIL dir%0d_target: got %h want %h", i, MEM_branch_target, tbl[i].pc4 + tbl[i].imm * 4);
      end
      total++;
      if ({MEM_write_reg, MEM_write_data, MEM_wb, MEM_m} !== {wr, tbl[i].d2, 2'(i), 3'(i)}) begin
        bad++; $display("FAIL dir%0d_fields: got %h want %h", i,
                        {MEM_write_reg, MEM_write_data, MEM_wb, MEM_m}, {wr, tbl[i].d2, 2'(i), 3'(i)});
      end
      last_res = tbl[i].res;
    end
  endtask

  task automatic test_random();
    logic [1:0]  op, wb;
    logic [2:0]  m;
    logic        src, dst;
    logic [31:0] d1, d2, imm, pc4, b, r;
    logic [4:0]  rt, rd, wr;
    logic [5:0]  f;
    logic [5:0]  flist[7];
    flist = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, 6'b000000};
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3)); src = 1'($urandom_range(0, 1)); dst = 1'($urandom_range(0, 1));
      wb = 2'($urandom); m = 3'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      d1 = $urandom; d2 = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
      pc4 = $urandom; imm = $urandom;
      f = flist[$urandom_range(0, 6)];
      if (f == 6'b000000) f = 6'($urandom);
`ifdef EX_MULT_EN
      if (f == F_MULT) f = F_AND;
`endif
      if (op == 2'b10) imm[5:0] = f;
      drive(wb, m, dst, op, src, pc4, d1, d2, imm, rt, rd);
      b = src ? imm : d2;
      r = ref_result(op, d1, b, imm[5:0]);
      exp_q.push_back(r);
      wr = dst ? rd : rt;
      #1;
      total++;
      if (ex_stall !== 1'b0) begin bad++; $display("FAIL rnd%0d_stall: got %b want 0", i, ex_stall); end
      @(posedge clk); #1;
      r = exp_q.pop_front();
      total++;
      if (MEM_alu_result !== r || MEM_zero !== (r == 32'd0)) begin
        bad++; $display("FAIL rnd%0d_result: got %h/%b want %h/%b", i, MEM_alu_result, MEM_zero, r, r == 32'd0);
      end
      total++;
      if ({MEM_branch_target, MEM_write_data, MEM_write_reg, MEM_wb, MEM_m} !==
          {pc4 + imm * 4, d2, wr, wb, m}) begin
        bad++; $display("FAIL rnd%0d_fields: got %h want %h", i,
                        {MEM_branch_target, MEM_write_data, MEM_write_reg, MEM_wb, MEM_m},
                        {pc4 + imm * 4, d2, wr, wb, m});
      end
      last_res = r;
    end
  endtask

`ifdef EX_MULT_EN
  // Multiplies issued back to back; each restarts from IDLE right after DONE.
  task automatic test_mult();
    logic [31:0] a[4];
    logic [31:0] b[4];
    logic [31:0] p;
    int cnt;
    a = '{32'd7, 32'hFFFFFFFF, $urandom, $urandom};
    b = '{32'd6, 32'd2, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 3'b101, 1'b1, 2'b10, 1'b0, 32'h0, a[k], b[k], {26'd0, F_MULT}, 5'd2, 5'd17);
      p = a[k] * b[k];
      #1;
      total++;
      if (ex_stall !== 1'b1) begin bad++; $display("FAIL mult%0d_stall_start: got %b want 1", k, ex_stall); end
      cnt = 1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        total++;
        if (MEM_wb !== 2'b00 || MEM_m !== 3'b000 || MEM_alu_result !== last_res) begin
          bad++; $display("FAIL mult%0d_bubble: got wb=%b m=%b res=%h want 0/0/%h", k, MEM_wb, MEM_m,
                          MEM_alu_result, last_res);
        end
        if (!ex_stall) break;
        cnt++;
      end
      total++;
      if (cnt != 33) begin bad++; $display("FAIL mult%0d_stall_len: got %0d want 33", k, cnt); end
      @(posedge clk); #1;
      total++;
      if (MEM_alu_result !== p || MEM_zero !== (p == 32'd0)) begin
        bad++; $display("FAIL mult%0d_product: got %h want %h", k, MEM_alu_result, p);
      end
      total++;
      if ({MEM_wb, MEM_m, MEM_write_reg} !== {2'b11, 3'b101, 5'd17}) begin
        bad++; $display("FAIL mult%0d_ctrl: got %h want %h", k, {MEM_wb, MEM_m, MEM_write_reg},
                        {2'b11, 3'b101, 5'd17});
      end
      last_res = p;
    end
  endtask
`else
  task automatic test_mult();
    drive(2'b10, 3'b011, 1'b1, 2'b10, 1'b0, 32'h0, 32'd7, 32'd6, {26'd0, F_MULT}, 5'd2, 5'd17);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (ex_stall !== 1'b0) begin bad++; $display("FAIL nomult%0d_stall: got %b want 0", c, ex_stall); end
      @(posedge clk); #1;
      total++;
      if (MEM_alu_result !== 32'd0 || MEM_zero !== 1'b1 || MEM_wb !== 2'b10 || MEM_m !== 3'b011) begin
        bad++; $display("FAIL nomult%0d_result: got %h/%b/%b/%b want 0/1/10/011", c,
                        MEM_alu_result, MEM_zero, MEM_wb, MEM_m);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
`ifdef EX_MULT_EN
    drive(2'b11, 3'b111, 1'b1, 2'b10, 1'b0, 32'h40, 32'd9, 32'd9, {26'd0, F_MULT}, 5'd4, 5'd5);
    // Eleven edges after issue puts the multiplier at BUSY with counter 10.
    for (int c = 0; c < 11; c++) begin @(posedge clk); #1; end
`else
    drive(2'b11, 3'b111, 1'b1, 2'b00, 1'b0, 32'h40, 32'd9, 32'd9, 32'h0, 5'd4, 5'd5);
    @(posedge clk); #1;
`endif
    #2 startin_n = 1'b0;
    #1;
    total++;
    if (ex_stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", ex_stall); end
    total++;
    if ({MEM_wb, MEM_m, MEM_zero, MEM_write_reg, MEM_branch_target, MEM_alu_result, MEM_write_data} !== 107'd0) begin
      bad++; $display("FAIL rstmid_outputs: got %h want 0",
                      {MEM_wb, MEM_m, MEM_zero, MEM_write_reg, MEM_branch_target, MEM_alu_result, MEM_write_data});
    end
    drive(2'b01, 3'b010, 1'b0, 2'b00, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd6, 5'd7);
    #1 startin_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (ex_stall !== 1'b0) begin bad++; $display("FAIL rstmid%0d_add_stall: got %b want 0", c, ex_stall); end
      @(posedge clk); #1;
      total++;
      if (MEM_alu_result !== 32'd2 || MEM_write_reg !== 5'd6 || MEM_wb !== 2'b01) begin
        bad++; $display("FAIL rstmid%0d_add: got %h/%h/%b want 2/6/01", c, MEM_alu_result, MEM_write_reg, MEM_wb);
      end
    end
  endtask

  initial begin
    last_res = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_mult();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
